// File: rtl/ad_mean_acquire.sv
// Drives a parallel ADC through 2^AVG_LOG2 conversions and publishes their signed sum.
// A busy line that never completes a conversion aborts the run with a one-cycle error pulse.
module ad_mean_acquire #(
    parameter int AD_WIDTH      = 16,
    parameter int AVG_LOG2      = 3,
    parameter int CONVST_CYCLES = 4,
    parameter int RD_CYCLES     = 3,
    parameter int BUSY_TIMEOUT  = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sta,
    input  logic                         ad_busy,
    input  logic [AD_WIDTH-1:0]          ad_data,
    output logic                         ad_convst,
    output logic                         ad_cs_n,
    output logic                         ad_rd_n,
    output logic [AD_WIDTH+AVG_LOG2-1:0] ad_mean,
    output logic                         done_sig,
    output logic                         err_sig
);

    localparam int ACC_W  = AD_WIDTH + AVG_LOG2;
    localparam int PH_MAX = (CONVST_CYCLES > RD_CYCLES) ? CONVST_CYCLES : RD_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [PH_W-1:0]     CONVST_LAST = PH_W'(CONVST_CYCLES - 1);
    localparam logic [PH_W-1:0]     RD_LAST     = PH_W'(RD_CYCLES - 1);
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [AVG_LOG2-1:0] SMP_LAST    = {AVG_LOG2{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVST  = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        READ    = 3'd4,
        ACC     = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t              state_r, state_s;
    logic                busy_meta_r, busy_sync_r;
    logic [PH_W-1:0]     phase_r, phase_s;
    logic [TO_W-1:0]     to_cnt_r, to_cnt_s;
    logic [AVG_LOG2-1:0] smp_cnt_r, smp_cnt_s;
    logic [ACC_W-1:0]    acc_r, acc_s;
    logic [AD_WIDTH-1:0] sample_r, sample_s;
    logic [ACC_W-1:0]    mean_r, mean_s;
    logic                done_r, done_s;
    logic                err_r, err_s;
    logic                convst_r, cs_n_r, rd_n_r;

    function automatic logic [ACC_W-1:0] sign_extend(input logic [AD_WIDTH-1:0] v);
        return {{AVG_LOG2{v[AD_WIDTH-1]}}, v};
    endfunction

    // Two-flop synchronizer for the asynchronous ADC busy line
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_meta_r <= 1'b0;
            busy_sync_r <= 1'b0;
        end else begin
            busy_meta_r <= ad_busy;
            busy_sync_r <= busy_meta_r;
        end
    end

    // Next-state and datapath decode for the acquisition sequence
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        to_cnt_s  = to_cnt_r;
        smp_cnt_s = smp_cnt_r;
        acc_s     = acc_r;
        sample_s  = sample_r;
        mean_s    = mean_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (sta) begin
                    acc_s     = '0;
                    smp_cnt_s = '0;
                    phase_s   = '0;
                    state_s   = CONVST;
                end else begin
                    state_s = IDLE;
                end
            end
            CONVST: begin
                if (phase_r == CONVST_LAST) begin
                    phase_s  = '0;
                    to_cnt_s = '0;
                    state_s  = WAIT_HI;
                end else begin
                    phase_s = phase_r + PH_W'(1);
                end
            end
            WAIT_HI: begin
                // Timeout wins over any busy edge seen in the same cycle
                if (to_cnt_r == TO_LAST) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else if (busy_sync_r) begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                    state_s  = WAIT_LO;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            WAIT_LO: begin
                if (to_cnt_r == TO_LAST) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else if (!busy_sync_r) begin
                    to_cnt_s = '0;
                    phase_s  = '0;
                    state_s  = READ;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            READ: begin
                if (phase_r == RD_LAST) begin
                    sample_s = ad_data;
                    phase_s  = '0;
                    state_s  = ACC;
                end else begin
                    phase_s = phase_r + PH_W'(1);
                end
            end
            ACC: begin
                acc_s = acc_r + sign_extend(sample_r);
                if (smp_cnt_r == SMP_LAST) begin
                    state_s = DONE;
                end else begin
                    smp_cnt_s = smp_cnt_r + AVG_LOG2'(1);
                    phase_s   = '0;
                    state_s   = CONVST;
                end
            end
            DONE: begin
                mean_s  = acc_r;
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and ADC pin registers; pins follow the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            phase_r   <= '0;
            to_cnt_r  <= '0;
            smp_cnt_r <= '0;
            acc_r     <= '0;
            sample_r  <= '0;
            mean_r    <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            convst_r  <= 1'b1;
            cs_n_r    <= 1'b1;
            rd_n_r    <= 1'b1;
        end else begin
            state_r   <= state_s;
            phase_r   <= phase_s;
            to_cnt_r  <= to_cnt_s;
            smp_cnt_r <= smp_cnt_s;
            acc_r     <= acc_s;
            sample_r  <= sample_s;
            mean_r    <= mean_s;
            done_r    <= done_s;
            err_r     <= err_s;
            convst_r  <= (state_s != CONVST);
            cs_n_r    <= (state_s != READ);
            rd_n_r    <= (state_s != READ);
        end
    end

    assign ad_convst = convst_r;
    assign ad_cs_n   = cs_n_r;
    assign ad_rd_n   = rd_n_r;
    assign ad_mean   = mean_r;
    assign done_sig  = done_r;
    assign err_sig   = err_r;

endmodule

// File: doc/ad_mean_acquire.md
AD_MEAN_ACQUIRE -- requirements
Module: ad_mean_acquire

Interface
REQ-001 Parameter AD_WIDTH, default 16: width of one signed ADC sample.
REQ-002 Parameter AVG_LOG2, default 3: log2 of conversions summed per result (8).
REQ-003 Parameter CONVST_CYCLES, default 4: ad_convst low width in clocks.
REQ-004 Parameter RD_CYCLES, default 3: ad_rd_n low width in clocks.
REQ-005 Parameter BUSY_TIMEOUT, default 255: maximum clocks allowed for one conversion.
REQ-006 clk  in  1  system clock; the only clock.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 sta  in  1  one-cycle acquisition request.
REQ-009 ad_busy  in  1  ADC busy; asynchronous to clk.
REQ-010 ad_data  in  AD_WIDTH  ADC parallel data, two's complement.
REQ-011 ad_convst  out  1  conversion start; idle high; the rising edge starts a conversion.
REQ-012 ad_cs_n  out  1  ADC chip select, active low.
REQ-013 ad_rd_n  out  1  ADC read strobe, active low.
REQ-014 ad_mean  out  AD_WIDTH+AVG_LOG2 (19)  signed sum of 2^AVG_LOG2 samples; the downstream fixed-to-float stage consumes it.
REQ-015 done_sig  out  1  one-cycle pulse: ad_mean was updated this cycle.
REQ-016 err_sig  out  1  one-cycle pulse: acquisition aborted on timeout.

Function
REQ-017 The block SHALL pass ad_busy through a 2-flop synchronizer before any use.
REQ-018 FSM states SHALL be IDLE, CONVST, WAIT_HI, WAIT_LO, READ, ACC and DONE.
- IDLE: on sta=1, clear the accumulator and sample counter, then go to CONVST.
- CONVST: drive ad_convst low for exactly CONVST_CYCLES clocks, then drive it high and go to WAIT_HI.
- WAIT_HI: wait for synced busy=1, then go to WAIT_LO.
- WAIT_LO: wait for synced busy=0, then go to READ.
- READ: drive ad_cs_n and ad_rd_n low for RD_CYCLES clocks; register ad_data on the last low cycle; release both high; go to ACC.
- ACC: add the sign-extended sample to the accumulator. If counter = 2^AVG_LOG2-1, go to DONE; otherwise increment the counter and go to CONVST.
- DONE: load ad_mean from the accumulator, pulse done_sig, go to IDLE.
REQ-019 The accumulator SHALL be AD_WIDTH+AVG_LOG2 bits signed; it cannot overflow; there is no rounding and no division.
REQ-020 ad_mean SHALL change only in DONE and SHALL hold its value otherwise.
REQ-021 done_sig and ad_mean SHALL update in the same clock edge, so ad_mean is valid while done_sig=1.
REQ-022 sta asserted outside IDLE SHALL be ignored: no queuing, no restart.
REQ-023 A timeout counter SHALL start on entry to WAIT_HI and clear on entry to READ. On reaching BUSY_TIMEOUT the FSM SHALL go to IDLE and pulse err_sig; ad_cs_n, ad_rd_n and ad_convst return high and ad_mean is unchanged.
REQ-024 sta and a timeout occurring in the same cycle SHALL resolve as timeout; the sta is dropped.
REQ-025 done_sig and err_sig SHALL never be high together.
REQ-026 ad_cs_n SHALL be low only in READ.
REQ-027 ad_rd_n low SHALL imply ad_cs_n low.
REQ-028 ad_convst SHALL be low only in CONVST.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL enter IDLE and set: ad_convst=1, ad_cs_n=1, ad_rd_n=1, ad_mean=0, done_sig=0, err_sig=0, with accumulator, counters and synchronizer cleared.
REQ-030 rst mid-acquisition SHALL abort at once with the REQ-029 values; no done_sig is emitted for the partial sum.

Verification
REQ-031 ADC model with busy high 20 clocks and data=16'h0100 for all 8 conversions; one sta pulse -> ad_convst low exactly 4 clocks per conversion, exactly 8 READ windows, ad_mean=19'h00800, one done_sig.
REQ-032 Data alternating 16'h7FFF and 16'h8000 -> ad_mean=19'h7FFFC (-4). All 8 samples 16'h8000 -> ad_mean=19'h40000 (-262144), no wrap.
REQ-033 ad_busy never rises after the first convst -> err_sig pulses once, 255 clocks after WAIT_HI entry; no done_sig; ad_mean keeps its previous value; next sta acquires normally.
REQ-034 sta re-pulsed during READ of conversion 3 -> ignored: exactly one done_sig, sum correct.
REQ-035 rst asserted during conversion 5 -> all outputs at reset values next cycle; no done_sig; a fresh sta yields a correct full 8-sample sum.
REQ-036 Back-to-back sta issued the cycle after done_sig -> second acquisition starts; both ad_mean values are correct and done_sig pulses are separated.
